// File: rtl/lmc_core_if.sv
// Little Man Computer bus bundle: program-load port plus the input and output
// valid/ready handshakes.
//   load_en/load_addr/load_data : program-load write port (honoured only while halted)
//   in_data/in_valid/in_ready   : input word for INP, ready while the core waits
//   out_data/out_valid/out_ready: registered output word from OUT
// master = environment side, slave = core side.
interface lmc_core_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output load_en, load_addr, load_data, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  load_en, load_addr, load_data, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/lmc_core.sv
// Little Man Computer core: accumulator machine with 2**ADDR_WIDTH words of
// unified program/data memory, a fetch/execute sequencer and blocking I/O.
//   timer555 : sole clock, rising edge
//   rst_n    : asynchronous active-low reset (memory contents are kept)
//   start    : one-cycle pulse, starts execution at address 0 when halted
//   bus      : load port and in/out handshakes (lmc_core_if.slave)
//   acc, pc  : architectural registers
//   z_flag   : acc == 0;  pz_flag : acc MSB == 0
//   halted   : core is in the halt state
module lmc_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  timer555,
  input  logic                  rst_n,
  input  logic                  start,
  lmc_core_if.slave             bus,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  z_flag,
  output logic                  pz_flag,
  output logic                  halted
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  // Opcode and operand fields must not overlap.
  if (DATA_WIDTH < ADDR_WIDTH + 4) begin : gen_bad_width
    $error("lmc_core: DATA_WIDTH must be at least ADDR_WIDTH+4");
  end

  localparam logic [3:0] OpHlt = 4'd0;
  localparam logic [3:0] OpAdd = 4'd1;
  localparam logic [3:0] OpSub = 4'd2;
  localparam logic [3:0] OpSta = 4'd3;
  localparam logic [3:0] OpLda = 4'd4;
  localparam logic [3:0] OpBra = 4'd5;
  localparam logic [3:0] OpBrz = 4'd6;
  localparam logic [3:0] OpBrp = 4'd7;
  localparam logic [3:0] OpInp = 4'd8;
  localparam logic [3:0] OpOut = 4'd9;

  typedef enum logic [2:0] {StHalt, StFetch, StExec, StWaitIn, StWaitOut} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [3:0]            ir_op_q, ir_op_d;
  logic [ADDR_WIDTH-1:0] ir_arg_q, ir_arg_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Operand read is combinational so EXEC completes in one cycle.
  assign mem_rdata = mem_q[ir_arg_q];

  assign z_flag  = (acc_q == '0);
  assign pz_flag = ~acc_q[DATA_WIDTH-1];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    ir_op_d     = ir_op_q;
    ir_arg_d    = ir_arg_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mem_we      = 1'b0;
    mem_waddr   = ir_arg_q;
    mem_wdata   = acc_q;

    case (state_q)
      StHalt: begin
        if (bus.load_en) begin
          mem_we    = 1'b1;
          mem_waddr = bus.load_addr;
          mem_wdata = bus.load_data;
        end
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
          acc_d   = '0;
        end
      end

      StFetch: begin
        ir_op_d  = mem_q[pc_q][DATA_WIDTH-1 -: 4];
        ir_arg_d = mem_q[pc_q][ADDR_WIDTH-1:0];
        pc_d     = pc_q + 1'b1;
        state_d  = StExec;
      end

      StExec: begin
        state_d = StFetch;
        case (ir_op_q)
          OpHlt: state_d = StHalt;
          OpAdd: acc_d = acc_q + mem_rdata;
          OpSub: acc_d = acc_q - mem_rdata;
          OpSta: mem_we = 1'b1;
          OpLda: acc_d = mem_rdata;
          OpBra: pc_d = ir_arg_q;
          OpBrz: if (z_flag) pc_d = ir_arg_q;
          OpBrp: if (pz_flag) pc_d = ir_arg_q;
          OpInp: state_d = StWaitIn;
          OpOut: begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
            state_d     = StWaitOut;
          end
          default: ;  // 10-15 behave as NOP
        endcase
      end

      StWaitIn: begin
        if (bus.in_valid) begin
          acc_d   = bus.in_data;
          state_d = StFetch;
        end
      end

      StWaitOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StFetch;
        end
      end

      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge timer555 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHalt;
      pc_q        <= '0;
      acc_q       <= '0;
      ir_op_q     <= '0;
      ir_arg_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      ir_op_q     <= ir_op_d;
      ir_arg_q    <= ir_arg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // No reset: program memory survives rst_n. Reset forces StHalt
  // asynchronously, so an in-flight STA never reaches this write.
  always_ff @(posedge timer555) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign acc           = acc_q;
  assign pc            = pc_q;
  assign halted        = (state_q == StHalt);
  assign bus.in_ready  = (state_q == StWaitIn);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_lmc_core.sv
// Directed self-checking bench for lmc_core: a default 8/4 instance and a
// 12/8 instance running the same I/O program.
module tb_lmc_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_w = 1'b0;
  always #5 clk = ~clk;

  lmc_core_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
  logic [7:0] acc;
  logic [3:0] pc;
  logic       z_flag, pz_flag, halted;

  lmc_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_dut (
    .timer555 (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .acc      (acc),
    .pc       (pc),
    .z_flag   (z_flag),
    .pz_flag  (pz_flag),
    .halted   (halted)
  );

  lmc_core_if #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) wbus ();
  logic [11:0] acc_w;
  logic [7:0]  pc_w;
  logic        z_flag_w, pz_flag_w, halted_w;

  lmc_core #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) u_dut_w (
    .timer555 (clk),
    .rst_n    (rst_n),
    .start    (start_w),
    .bus      (wbus),
    .acc      (acc_w),
    .pc       (pc_w),
    .z_flag   (z_flag_w),
    .pz_flag  (pz_flag_w),
    .halted   (halted_w)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick(1);
    bus.load_en   = 1'b0;
  endtask

  task automatic wload(input logic [7:0] a, input logic [11:0] d);
    wbus.load_en   = 1'b1;
    wbus.load_addr = a;
    wbus.load_data = d;
    tick(1);
    wbus.load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    bus.load_en  = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.in_data  = '0;   bus.in_valid  = 1'b0; bus.out_ready = 1'b0;
    wbus.load_en = 1'b0; wbus.load_addr = '0; wbus.load_data = '0;
    wbus.in_data = '0;   wbus.in_valid  = 1'b0; wbus.out_ready = 1'b0;

    // Reset values
    tick(2);
    check_eq("rst_halted", halted, 1'b1);
    check_eq("rst_pc", pc, 4'h0);
    check_eq("rst_acc", acc, 8'h00);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_out_data", bus.out_data, 8'h00);
    check_eq("rst_in_ready", bus.in_ready, 1'b0);
    rst_n = 1'b1;
    tick(3);
    check_eq("release_no_start", halted, 1'b1);

    // INP; ADD 10; OUT; HLT with mem[10]=3, input 5 -> output 8
    load(4'd0, 8'h80); load(4'd1, 8'h1A); load(4'd2, 8'h90); load(4'd3, 8'h00);
    load(4'd10, 8'h03);
    pulse_start();
    tick(2);
    check_eq("io_in_ready", bus.in_ready, 1'b1);
    tick(2);
    check_eq("io_in_hold", bus.in_ready, 1'b1);
    check_eq("io_in_hold_pc", pc, 4'h1);
    bus.in_data = 8'h05; bus.in_valid = 1'b1;
    tick(1);
    bus.in_valid = 1'b0;
    check_eq("io_in_acc", acc, 8'h05);
    check_eq("io_in_ready_drop", bus.in_ready, 1'b0);
    tick(4);
    check_eq("io_add_acc", acc, 8'h08);
    check_eq("io_out_valid", bus.out_valid, 1'b1);
    check_eq("io_out_data", bus.out_data, 8'h08);
    tick(3);
    check_eq("io_out_hold_valid", bus.out_valid, 1'b1);
    check_eq("io_out_hold_data", bus.out_data, 8'h08);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    check_eq("io_out_done", bus.out_valid, 1'b0);
    check_eq("io_out_retain", bus.out_data, 8'h08);
    tick(2);
    check_eq("io_halted", halted, 1'b1);
    check_eq("io_halt_pc", pc, 4'h4);

    // Branches: BRZ taken on 0, BRP not taken on 0x80, BRP taken on 0x7F
    load(4'd0, 8'h4C); load(4'd1, 8'h66); load(4'd6, 8'h4D); load(4'd7, 8'h70);
    load(4'd8, 8'h4E); load(4'd9, 8'h7B); load(4'd11, 8'h00);
    load(4'd12, 8'h00); load(4'd13, 8'h80); load(4'd14, 8'h7F);
    pulse_start();
    tick(2);
    check_eq("br_z_flag", z_flag, 1'b1);
    tick(2);
    check_eq("brz_taken", pc, 4'h6);
    tick(2);
    check_eq("br_acc80", acc, 8'h80);
    check_eq("br_pz_flag", pz_flag, 1'b0);
    tick(2);
    check_eq("brp_not_taken", pc, 4'h8);
    tick(4);
    check_eq("brp_taken", pc, 4'hB);
    tick(2);
    check_eq("br_halted", halted, 1'b1);

    // Arithmetic wrap: 0xFF+1 -> 0, 0-1 -> 0xFF
    load(4'd0, 8'h4C); load(4'd1, 8'h1D); load(4'd2, 8'h2D); load(4'd3, 8'h00);
    load(4'd12, 8'hFF); load(4'd13, 8'h01);
    pulse_start();
    tick(2);
    check_eq("ar_lda", acc, 8'hFF);
    tick(2);
    check_eq("ar_add_wrap", acc, 8'h00);
    check_eq("ar_add_z", z_flag, 1'b1);
    tick(2);
    check_eq("ar_sub_wrap", acc, 8'hFF);
    check_eq("ar_sub_pz", pz_flag, 1'b0);
    check_eq("ar_sub_z", z_flag, 1'b0);
    tick(2);
    check_eq("ar_halted", halted, 1'b1);

    // load_en and start while running are ignored; memory survives reset
    load(4'd0, 8'h4C); load(4'd1, 8'h51); load(4'd12, 8'h11);
    pulse_start();
    tick(2);
    check_eq("run_lda", acc, 8'h11);
    load(4'd12, 8'h55);  // during FETCH
    load(4'd12, 8'h55);  // during EXEC
    pulse_start();       // during FETCH
    check_eq("run_start_ignored_pc", pc, 4'h2);
    check_eq("run_start_ignored_acc", acc, 8'h11);
    tick(1);
    check_eq("run_loop_pc", pc, 4'h1);
    tick(2);
    check_eq("run_loop_pc2", pc, 4'h1);
    do_reset();
    pulse_start();
    tick(2);
    check_eq("run_mem_unchanged", acc, 8'h11);
    do_reset();

    // Wrap at top of memory and self-loop: BRA 14; 14 NOP; 15 BRA 15
    load(4'd0, 8'h5E); load(4'd14, 8'hA0); load(4'd15, 8'h5F);
    pulse_start();
    tick(2);
    check_eq("wr_bra", pc, 4'hE);
    tick(2);
    check_eq("wr_nop", pc, 4'hF);
    tick(1);
    check_eq("wr_wrap", pc, 4'h0);
    tick(1);
    check_eq("wr_loop", pc, 4'hF);
    tick(4);
    check_eq("wr_loop2", pc, 4'hF);
    do_reset();

    // Reset during WAIT_OUT: LDA 12; OUT; STA 13; HLT
    load(4'd0, 8'h4C); load(4'd1, 8'h90); load(4'd2, 8'h3D); load(4'd3, 8'h00);
    load(4'd12, 8'h3C); load(4'd13, 8'h00);
    pulse_start();
    bus.in_valid = 1'b1;  // must be ignored outside WAIT_IN
    tick(4);
    check_eq("wo_out_valid", bus.out_valid, 1'b1);
    check_eq("wo_out_data", bus.out_data, 8'h3C);
    tick(3);
    check_eq("wo_hold", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("wo_rst_halted", halted, 1'b1);
    check_eq("wo_rst_out_valid", bus.out_valid, 1'b0);
    check_eq("wo_rst_out_data", bus.out_data, 8'h00);
    check_eq("wo_rst_acc", acc, 8'h00);
    check_eq("wo_rst_pc", pc, 4'h0);
    check_eq("wo_rst_in_ready", bus.in_ready, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check_eq("wo_no_autostart", halted, 1'b1);
    bus.out_ready = 1'b1;
    pulse_start();
    tick(4);
    check_eq("wo_rerun_valid", bus.out_valid, 1'b1);
    check_eq("wo_rerun_data", bus.out_data, 8'h3C);
    tick(1);
    check_eq("wo_rerun_done", bus.out_valid, 1'b0);
    tick(4);
    bus.out_ready = 1'b0;
    check_eq("wo_rerun_halted", halted, 1'b1);
    load(4'd0, 8'h4D); load(4'd1, 8'h00);
    pulse_start();
    tick(2);
    check_eq("wo_sta_written", acc, 8'h3C);
    tick(2);
    check_eq("wo_final_halt", halted, 1'b1);

    // 12/8 instance, same I/O program, handshakes always ready
    wload(8'd0, 12'h800); wload(8'd1, 12'h10A); wload(8'd2, 12'h900);
    wload(8'd3, 12'h000); wload(8'd10, 12'h003);
    wbus.in_data = 12'h005; wbus.in_valid = 1'b1; wbus.out_ready = 1'b1;
    start_w = 1'b1;
    tick(1);
    start_w = 1'b0;
    tick(9);
    check_eq("w_not_yet_halted", halted_w, 1'b0);
    tick(1);
    check_eq("w_halted", halted_w, 1'b1);
    check_eq("w_out_data", wbus.out_data, 12'h008);
    check_eq("w_out_valid", wbus.out_valid, 1'b0);
    check_eq("w_acc", acc_w, 12'h008);
    check_eq("w_pc", pc_w, 8'h04);
    wbus.in_valid = 1'b0; wbus.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
